// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard generating the ID-stage stall.
// Optional stall statistics counters are built when SCOREBOARD_STATS_EN is defined.
module reg_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_reg_write,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    input  logic       kill_valid,
    input  logic [4:0] kill_rd,
    output logic       is_stall,
    output logic       issue_fire,
    output logic [5:0] pending_cnt,
    output logic       err_underflow
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] raw_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic [5:0]       pending_cnt_q, pending_cnt_d;
    logic             err_underflow_q, err_underflow_d;

    logic                wb_dec, kill_dec;
    logic [NUM_REGS-1:0] dec_hit;
    logic [NUM_REGS-1:0] busy;
    logic                rs1_busy, rs2_busy, rd_full;
    logic                raw_hit, waw_hit, inc_en;

    // A register with only one writer left that retires this cycle is readable
    // when the register file writes before it reads.
    always_comb begin
        wb_dec   = wb_valid & wb_reg_write & (wb_rd != 5'd0);
        kill_dec = kill_valid & (kill_rd != 5'd0);
        dec_hit  = '0;
        busy     = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            dec_hit[r] = (wb_dec && (wb_rd == 5'(r))) || (kill_dec && (kill_rd == 5'(r)));
            busy[r]    = (cnt_q[r] != '0) &&
                         !(WB_BYPASS && (cnt_q[r] == CNT_W'(1)) && dec_hit[r]);
        end
    end

    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        rd_full  = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (id_rs1 == 5'(r)) rs1_busy = busy[r];
            if (id_rs2 == 5'(r)) rs2_busy = busy[r];
            if (id_rd == 5'(r))  rd_full  = (cnt_q[r] == CNT_MAX) && !dec_hit[r];
        end
    end

    always_comb begin
        raw_hit    = (id_use_rs1 & rs1_busy) | (id_use_rs2 & rs2_busy);
        waw_hit    = id_reg_write & rd_full;
        is_stall   = id_valid & (raw_hit | waw_hit);
        issue_fire = id_valid & ~is_stall;
        inc_en     = issue_fire & id_reg_write & (id_rd != 5'd0);
    end

    // All events on one register fold into a single signed delta; a negative
    // result clamps to zero and raises the sticky underflow flag.
    always_comb begin
        err_underflow_d = err_underflow_q;
        pending_cnt_d   = '0;
        cnt_d[0]        = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            int net;
            net = int'(cnt_q[r])
                + int'(inc_en && (id_rd == 5'(r)))
                - int'(wb_dec && (wb_rd == 5'(r)))
                - int'(kill_dec && (kill_rd == 5'(r)));
            if (net < 0) begin
                cnt_d[r]        = '0;
                err_underflow_d = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(net);
            end
            if (cnt_d[r] != '0) pending_cnt_d = pending_cnt_d + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            pending_cnt_q   <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            pending_cnt_q   <= pending_cnt_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign pending_cnt   = pending_cnt_q;
    assign err_underflow = err_underflow_q;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] raw_stall_cycles_q, raw_stall_cycles_d;

    always_comb begin
        stall_cycles_d     = stall_cycles_q;
        raw_stall_cycles_d = raw_stall_cycles_q;
        if (is_stall && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (id_valid && raw_hit && (raw_stall_cycles_q != 32'hFFFF_FFFF))
            raw_stall_cycles_d = raw_stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q     <= '0;
            raw_stall_cycles_q <= '0;
        end else begin
            stall_cycles_q     <= stall_cycles_d;
            raw_stall_cycles_q <= raw_stall_cycles_d;
        end
    end

    assign stall_cycles     = stall_cycles_q;
    assign raw_stall_cycles = raw_stall_cycles_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed and randomized checks of reg_scoreboard against a counter-array model.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_reg_write = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic       wb_valid = 0, wb_reg_write = 0, kill_valid = 0;
    logic [4:0] wb_rd = 0, kill_rd = 0;
    logic       is_stall, issue_fire, err_underflow;
    logic [5:0] pending_cnt;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles, raw_stall_cycles;
    int          sc_m, rc_m;
`endif

    int total = 0;
    int bad   = 0;
    int cnt_m [32];
    bit err_m;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk          (clk),
        .reset        (reset_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .kill_valid   (kill_valid),
        .kill_rd      (kill_rd),
        .is_stall     (is_stall),
        .issue_fire   (issue_fire),
        .pending_cnt  (pending_cnt),
        .err_underflow(err_underflow)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .raw_stall_cycles(raw_stall_cycles)
`endif
    );

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic int pend_m();
        int n = 0;
        for (int r = 1; r < 32; r++) if (cnt_m[r] != 0) n++;
        return n;
    endfunction

    function automatic bit dec_m(int r);
        return (r != 0) && ((wb_valid && wb_reg_write && wb_rd == r) || (kill_valid && kill_rd == r));
    endfunction

    function automatic bit busy_m(int r);
        return (r != 0) && (cnt_m[r] != 0) && !(cnt_m[r] == 1 && dec_m(r));
    endfunction

    function automatic bit raw_m();
        return id_valid && ((id_use_rs1 && busy_m(id_rs1)) || (id_use_rs2 && busy_m(id_rs2)));
    endfunction

    function automatic bit stall_m();
        return raw_m() || (id_valid && id_reg_write && id_rd != 0 && cnt_m[id_rd] == 3 && !dec_m(id_rd));
    endfunction

    task automatic clear_model();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        err_m = 0;
`ifdef SCOREBOARD_STATS_EN
        sc_m = 0;
        rc_m = 0;
`endif
    endtask

    task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit rw,
                         bit wv, int wrd, bit kv, int krd);
        id_valid = v; id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
        id_rd = 5'(rd); id_reg_write = rw;
        wb_valid = wv; wb_reg_write = wv; wb_rd = 5'(wrd);
        kill_valid = kv; kill_rd = 5'(krd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Entered shortly after a rising edge with inputs already applied.
    task automatic step(string tag);
        bit st, fire, rw;
        int net;
        #3;
        st   = stall_m();
        rw   = raw_m();
        fire = id_valid && !st;
        check({tag, ":stall"}, is_stall, st);
        check({tag, ":fire"}, issue_fire, fire);
        check({tag, ":pending"}, pending_cnt, pend_m());
        check({tag, ":err"}, err_underflow, err_m);
`ifdef SCOREBOARD_STATS_EN
        check({tag, ":stall_cycles"}, stall_cycles, sc_m);
        check({tag, ":raw_cycles"}, raw_stall_cycles, rc_m);
        if (st) sc_m++;
        if (rw) rc_m++;
`endif
        for (int r = 1; r < 32; r++) begin
            net = cnt_m[r];
            if (fire && id_reg_write && id_rd == r) net++;
            if (wb_valid && wb_reg_write && wb_rd == r) net--;
            if (kill_valid && kill_rd == r) net--;
            if (net < 0) begin
                net   = 0;
                err_m = 1;
            end
            cnt_m[r] = net;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(string tag);
        reset_n = 1'b0;
        #1;
        clear_model();
        check({tag, ":rst_stall"}, is_stall, 0);
        check({tag, ":rst_fire"}, issue_fire, id_valid);
        check({tag, ":rst_pending"}, pending_cnt, 0);
        check({tag, ":rst_err"}, err_underflow, 0);
`ifdef SCOREBOARD_STATS_EN
        check({tag, ":rst_stall_cycles"}, stall_cycles, 0);
        check({tag, ":rst_raw_cycles"}, raw_stall_cycles, 0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        clear_model();
        #2;
        drive(1, 5, 1, 6, 1, 7, 1, 0, 0, 0, 0);
        do_reset("init");

        drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);   step("b2b_issue");
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);   step("b2b_stall0");
        check("b2b_cnt5", cnt_m[5], 1);
        step("b2b_stall1");
        drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);   step("b2b_bypass");
        idle();                                    step("b2b_idle");

        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);   step("x0_issue");
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);   step("x0_read");
        idle();                                    step("x0_idle");

        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); step("ovf_fill");
        end
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);   step("ovf_full");
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0);   step("ovf_indep");
        drive(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0);   step("ovf_wbfire");
        check("ovf_cnt7", cnt_m[7], 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0); step("ovf_drain");
        end

        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);   step("sim_issue");
        drive(1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 0);   step("sim_both");
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);   step("sim_after");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);   step("sim_drain");

        drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);   step("kill_issue");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);   step("kill_kill");
        drive(1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0);   step("kill_wb");
        idle();                                    step("kill_flag");
        check("kill_err_model", err_m, 1);

        drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);   step("ar_issue");
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check("ar_prestall", is_stall, 1);
        do_reset("ar");
        step("ar_after");

        for (int i = 0; i < 900; i++) begin
            int wr;
            if (i % 300 == 299) do_reset("rnd");
            wr           = $urandom_range(1, 9);
            id_valid     = ($urandom_range(0, 9) < 7);
            id_rs1       = 5'($urandom_range(0, 9));
            id_rs2       = 5'($urandom_range(0, 9));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            id_rd        = 5'($urandom_range(0, 9));
            id_reg_write = ($urandom_range(0, 3) != 0);
            wb_rd        = 5'(wr);
            wb_valid     = (cnt_m[wr] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            wb_reg_write = ($urandom_range(0, 7) != 0);
            kill_valid   = ($urandom_range(0, 19) == 0);
            kill_rd      = 5'($urandom_range(0, 9));
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-register pending-write tracker for the 5-stage RISC-V pipeline. It replaces the combinational EX/MEM rd comparison that currently produces is_stall.
- The ID stage records each issued destination register as "pending". The WB stage, or a squash, retires it.
- ID source reads are checked against the pending set, and the block generates is_stall.
- The block sits beside the ID stage. Its is_stall output gates the PC write enable and the IF/ID write enable, and inserts a bubble into ID/EX.

Parameters:
- NUM_REGS, 32, number of architectural registers (x0 is never tracked).
- CNT_W, 2, width of each per-register in-flight counter; at most 2^CNT_W-1 writers per register.
- WB_BYPASS, 1, when set, a register whose last pending write retires this cycle is treated as not busy (the register file writes before it reads).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  a valid instruction occupies ID.
- id_rs1  in  5  source register 1.
- id_rs2  in  5  source register 2.
- id_use_rs1  in  1  the instruction reads rs1.
- id_use_rs2  in  1  the instruction reads rs2.
- id_rd  in  5  destination register.
- id_reg_write  in  1  the instruction writes rd.
- wb_valid  in  1  an instruction retires in WB this cycle.
- wb_rd  in  5  retiring destination.
- wb_reg_write  in  1  the retiring instruction wrote rd.
- kill_valid  in  1  an issued instruction is squashed this cycle.
- kill_rd  in  5  destination of the squashed instruction.
- is_stall  out  1  hold ID (combinational from state and inputs).
- issue_fire  out  1  an instruction leaves ID this cycle (id_valid & !is_stall).
- pending_cnt  out  6  number of registers with a nonzero counter (registered).
- err_underflow  out  1  sticky; a decrement hit a zero counter.

Behaviour:
- Reset (asynchronous, reset=0): all counters, pending_cnt and err_underflow go to 0. Consequently is_stall=0 and issue_fire=id_valid. Assertion takes effect immediately, including mid-stall; the first edge after deassertion operates normally.
- Register busy(r):
  - True when cnt[r]!=0, except when WB_BYPASS=1, cnt[r]==1, and a decrement of r occurs this cycle.
  - busy(0) is always 0.
- Stall conditions. is_stall=1 when id_valid and any of the following holds:
  - id_use_rs1 & busy(id_rs1);
  - id_use_rs2 & busy(id_rs2);
  - WAW overflow: id_reg_write & id_rd!=0 & cnt[id_rd]==2^CNT_W-1 with no decrement of id_rd this cycle.
- Increment: when issue_fire & id_reg_write & id_rd!=0, cnt[id_rd] increments.
- Decrement sources, evaluated per edge:
  - WB: wb_valid & wb_reg_write & wb_rd!=0 decrements cnt[wb_rd].
  - Kill: kill_valid & kill_rd!=0 decrements cnt[kill_rd].
- Simultaneous events, all resolved per register as net = inc - dec_wb - dec_kill:
  - WB and kill on the same register: the counter decrements by 2.
  - Increment and decrement on the same register: the counter is unchanged.
- Underflow: if the net result would go below 0, the counter clamps at 0 and err_underflow sets. It stays set until reset.
- pending_cnt: the population count of nonzero counters after the update. It is registered, so it reflects the new state one cycle after the event.
- x0: writes to x0 never increment, and decrements of x0 are ignored without flagging an error.
- Latency:
  - An issued writer makes its rd busy to the next ID instruction, i.e. a stall in the following cycle.
  - A WB retire clears busy in the same cycle when WB_BYPASS=1, otherwise in the next cycle.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- Defined:
  - Adds output stall_cycles (32 bits), which increments on every cycle with is_stall=1 and saturates at 0xFFFFFFFF.
  - Adds output raw_stall_cycles (32 bits), which counts only stalls caused by rs1/rs2 and excludes stalls caused only by WAW overflow.
  - Both reset to 0.
- Undefined: neither port nor its counters exists; all other behaviour is identical.

Test Plan:
- Back-to-back dependency:
  - Stimulus: issue add x5 (rd=5); next cycle, id rs1=5 with use_rs1=1.
  - Required response: is_stall=1. Stall holds until wb_valid with wb_rd=5; with WB_BYPASS=1, is_stall=0 in that same cycle.
- x0 immunity:
  - Stimulus: issue rd=0; next instruction rs1=0, rs2=0.
  - Required response: is_stall=0, pending_cnt stays 0.
- Overflow:
  - Stimulus: issue three writers to x7 with no retires.
  - Required response: cnt[x7]=3. A fourth writer to x7 gives is_stall=1 while an independent reader of x8 gives is_stall=0. A WB of x7 in the stalled cycle lets the fourth writer fire, leaving cnt[x7]=3.
- Simultaneous events:
  - Stimulus: issue rd=9 and WB rd=9 on the same edge, starting from cnt[x9]=1.
  - Required response: cnt[x9] stays 1 and pending_cnt is unchanged.
- Kill and underflow:
  - Stimulus: issue rd=3, then kill_rd=3, then a further WB of rd=3.
  - Required response: cnt[x3]=0 after the kill. After the WB, err_underflow=1 and the counter stays 0.
- Asynchronous reset:
  - Stimulus: with x4 pending and is_stall=1, assert reset=0 between clock edges.
  - Required response: is_stall=0 and pending_cnt=0 immediately, without waiting for an edge. With SCOREBOARD_STATS_EN, stall_cycles=0.
